// File: rtl/rf_pkg.sv
// Shared state encoding, zero-register constant and port-slice helper for the register bank.
// Pure definitions: no logic, no latency, no backpressure.
`ifndef RF_PKG_SV
`define RF_PKG_SV

`define RF_SLICE(idx, w) ((idx) * (w)) +: (w)

package rf_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } rf_state_e;

  localparam int unsigned REG_ZERO = 0;

endpackage

`endif

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on issue, cleared on write-back, issue wins; bit 0 tied low.
// Updates one edge after the strobe; no backpressure, updates gated off while the bank is clearing.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_rd,
  input  logic             wr0_en,
  input  logic [AW-1:0]    wr0_addr,
  input  logic             wr1_en,
  input  logic [AW-1:0]    wr1_addr,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (en) begin
      if (wr0_en) busy_d[wr0_addr] = 1'b0;
      if (wr1_en) busy_d[wr1_addr] = 1'b0;
      if (iss_en) busy_d[iss_rd]   = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register bank: NRD combinational read ports with write bypass, two prioritised write ports.
// Read latency 0, write latency 1; no backpressure, all traffic ignored until the post-reset clear finishes.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS),
  parameter int NRD   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic                wr0_en,
  input  logic [AW-1:0]       wr0_addr,
  input  logic [XLEN-1:0]     wr0_data,
  input  logic                wr1_en,
  input  logic [AW-1:0]       wr1_addr,
  input  logic [XLEN-1:0]     wr1_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd,
  output logic [NREGS-1:0]    busy,
  output logic                ready
);

  rf_state_e       state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];
  logic            live;
  logic            wr0_ok, wr1_ok;

  assign live   = (state_q == ST_READY);
  assign wr0_ok = live && wr0_en && (wr0_addr != AW'(REG_ZERO));
  assign wr1_ok = live && wr1_en && (wr1_addr != AW'(REG_ZERO));
  assign ready  = live;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + AW'(1);
      if (clr_cnt_q == AW'(NREGS - 1)) state_d = ST_READY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // wr1 is applied last so it wins a same-address collision
  always_comb begin
    mem_d = mem_q;
    if (state_q == ST_CLEAR) begin
      mem_d[clr_cnt_q] = '0;
    end else begin
      if (wr0_ok) mem_d[wr0_addr] = wr0_data;
      if (wr1_ok) mem_d[wr1_addr] = wr1_data;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] val;

    assign a = rd_addr[`RF_SLICE(k, AW)];

    always_comb begin
      val = '0;
      if (live && (a != AW'(REG_ZERO))) begin
        if (wr1_ok && (wr1_addr == a))      val = wr1_data;
        else if (wr0_ok && (wr0_addr == a)) val = wr0_data;
        else                                val = mem_q[a];
      end
    end

    assign rd_data[`RF_SLICE(k, XLEN)] = val;
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .en       (live),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .busy     (busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default instance (64b x 32, 2 ports) and a narrow one (32b x 16, 4 ports) driven in lockstep.
// A behavioural model tracks clear progress, array contents and busy bits from the architectural rules.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_a, rst_b;
  logic [9:0]   rd_addr_a;
  logic [127:0] rd_data_a;
  logic [15:0]  rd_addr_b;
  logic [127:0] rd_data_b;
  logic         wr0_en_a, wr1_en_a, iss_en_a, wr0_en_b, wr1_en_b, iss_en_b;
  logic [4:0]   wr0_addr_a, wr1_addr_a, iss_rd_a;
  logic [3:0]   wr0_addr_b, wr1_addr_b, iss_rd_b;
  logic [63:0]  wr0_data_a, wr1_data_a;
  logic [31:0]  wr0_data_b, wr1_data_b;
  logic [31:0]  busy_a;
  logic [15:0]  busy_b;
  logic         ready_a, ready_b;

  regfile_mp #(.XLEN(64), .NREGS(32), .NRD(2)) dut_a (
    .clk(clk), .rst(rst_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .wr0_en(wr0_en_a), .wr0_addr(wr0_addr_a), .wr0_data(wr0_data_a),
    .wr1_en(wr1_en_a), .wr1_addr(wr1_addr_a), .wr1_data(wr1_data_a),
    .iss_en(iss_en_a), .iss_rd(iss_rd_a), .busy(busy_a), .ready(ready_a)
  );

  regfile_mp #(.XLEN(32), .NREGS(16), .NRD(4)) dut_b (
    .clk(clk), .rst(rst_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .wr0_en(wr0_en_b), .wr0_addr(wr0_addr_b), .wr0_data(wr0_data_b),
    .wr1_en(wr1_en_b), .wr1_addr(wr1_addr_b), .wr1_data(wr1_data_b),
    .iss_en(iss_en_b), .iss_rd(iss_rd_b), .busy(busy_b), .ready(ready_b)
  );

  // logical stimulus per instance (0 = default, 1 = narrow)
  logic        g_rst [2];
  int          g_rd  [2][4];
  logic        g_w0en[2], g_w1en[2], g_iss[2];
  int          g_w0a [2], g_w1a [2], g_isa[2];
  logic [63:0] g_w0d [2], g_w1d [2];

  // reference model
  int          m_cnt [2];
  logic [63:0] m_mem [2][32];
  logic [31:0] m_busy[2];

  int vectors = 0;
  int miscompares = 0;

  function automatic int nregs(int d); return (d == 0) ? 32 : 16; endfunction
  function automatic int nrd(int d);   return (d == 0) ? 2 : 4;   endfunction
  function automatic logic [63:0] fit(int d, logic [63:0] v);
    return (d == 0) ? v : {32'h0, v[31:0]};
  endfunction
  function automatic logic m_ready(int d); return m_cnt[d] >= nregs(d); endfunction

  function automatic logic [63:0] exp_rd(int d, int k);
    int a;
    a = g_rd[d][k];
    if (!m_ready(d) || a == 0) return 64'h0;
    if (g_w1en[d] && g_w1a[d] == a) return g_w1d[d];
    if (g_w0en[d] && g_w0a[d] == a) return g_w0d[d];
    return m_mem[d][a];
  endfunction

  function automatic logic [63:0] obs_rd(int d, int k);
    if (d == 0) return rd_data_a[k*64 +: 64];
    return {32'h0, rd_data_b[k*32 +: 32]};
  endfunction
  function automatic logic [63:0] obs_busy(int d);
    return (d == 0) ? {32'h0, busy_a} : {48'h0, busy_b};
  endfunction
  function automatic logic obs_ready(int d);
    return (d == 0) ? ready_a : ready_b;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    rst_a = g_rst[0];
    rst_b = g_rst[1];
    for (int k = 0; k < 2; k++) rd_addr_a[k*5 +: 5] = g_rd[0][k][4:0];
    for (int k = 0; k < 4; k++) rd_addr_b[k*4 +: 4] = g_rd[1][k][3:0];
    wr0_en_a = g_w0en[0]; wr0_addr_a = g_w0a[0][4:0]; wr0_data_a = g_w0d[0];
    wr1_en_a = g_w1en[0]; wr1_addr_a = g_w1a[0][4:0]; wr1_data_a = g_w1d[0];
    iss_en_a = g_iss[0];  iss_rd_a   = g_isa[0][4:0];
    wr0_en_b = g_w0en[1]; wr0_addr_b = g_w0a[1][3:0]; wr0_data_b = g_w0d[1][31:0];
    wr1_en_b = g_w1en[1]; wr1_addr_b = g_w1a[1][3:0]; wr1_data_b = g_w1d[1][31:0];
    iss_en_b = g_iss[1];  iss_rd_b   = g_isa[1][3:0];
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (g_rst[d]) begin
        m_cnt[d]  = 0;
        m_busy[d] = '0;
        for (int r = 0; r < 32; r++) m_mem[d][r] = '0;
      end else if (!m_ready(d)) begin
        m_cnt[d]++;
      end else begin
        if (g_w0en[d] && g_w0a[d] != 0) m_mem[d][g_w0a[d]] = g_w0d[d];
        if (g_w1en[d] && g_w1a[d] != 0) m_mem[d][g_w1a[d]] = g_w1d[d];
        if (g_w0en[d]) m_busy[d][g_w0a[d]] = 1'b0;
        if (g_w1en[d]) m_busy[d][g_w1a[d]] = 1'b0;
        if (g_iss[d] && g_isa[d] != 0) m_busy[d][g_isa[d]] = 1'b1;
      end
    end
  endtask

  // pre: apply inputs and check combinational reads; post: clock edge and check state
  task automatic pre(bit chk_rd);
    drive();
    #2;
    if (chk_rd)
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < nrd(d); k++)
          chk($sformatf("rd_d%0d_p%0d", d, k), obs_rd(d, k), exp_rd(d, k));
  endtask

  task automatic post();
    model_step();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("ready_d%0d", d), 64'(obs_ready(d)), 64'(m_ready(d)));
      chk($sformatf("busy_d%0d", d), obs_busy(d), 64'(m_busy[d]));
    end
  endtask

  task automatic cycle(); pre(1'b1); post(); endtask

  task automatic idle();
    for (int d = 0; d < 2; d++) begin
      g_rst[d] = 1'b0; g_w0en[d] = 1'b0; g_w1en[d] = 1'b0; g_iss[d] = 1'b0;
      g_w0a[d] = 0; g_w1a[d] = 0; g_isa[d] = 0; g_w0d[d] = '0; g_w1d[d] = '0;
      for (int k = 0; k < 4; k++) g_rd[d][k] = 0;
    end
  endtask

  task automatic set_rst(logic v); g_rst[0] = v; g_rst[1] = v; endtask
  task automatic wr(int port, int a, logic [63:0] v);
    for (int d = 0; d < 2; d++) begin
      if (port == 0) begin g_w0en[d] = 1'b1; g_w0a[d] = a; g_w0d[d] = fit(d, v); end
      else           begin g_w1en[d] = 1'b1; g_w1a[d] = a; g_w1d[d] = fit(d, v); end
    end
  endtask
  task automatic rdp(int k, int a); g_rd[0][k] = a; g_rd[1][k] = a; endtask
  task automatic iss(int a); g_iss[0] = 1'b1; g_isa[0] = a; g_iss[1] = 1'b1; g_isa[1] = a; endtask

  task automatic rand_in(bit allow_rst);
    for (int d = 0; d < 2; d++) begin
      int n;
      n = nregs(d);
      g_rst[d]  = allow_rst && ($urandom_range(0, 149) == 0);
      g_w0en[d] = 1'($urandom_range(0, 1));
      g_w0a[d]  = int'($urandom_range(0, n - 1));
      g_w0d[d]  = fit(d, {$urandom, $urandom});
      g_w1en[d] = 1'($urandom_range(0, 1));
      g_w1a[d]  = ($urandom_range(0, 3) == 0) ? g_w0a[d] : int'($urandom_range(0, n - 1));
      g_w1d[d]  = fit(d, {$urandom, $urandom});
      g_iss[d]  = 1'($urandom_range(0, 1));
      g_isa[d]  = ($urandom_range(0, 3) == 0) ? g_w0a[d] : int'($urandom_range(0, n - 1));
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 3))
          0:       g_rd[d][k] = g_w0a[d];
          1:       g_rd[d][k] = g_w1a[d];
          default: g_rd[d][k] = int'($urandom_range(0, n - 1));
        endcase
      end
    end
  endtask

  initial begin
    idle();
    set_rst(1'b1);
    pre(1'b0);
    post();

    // clear sequence with a write and an issue attempted mid-clear
    for (int e = 1; e <= 32; e++) begin
      idle();
      for (int k = 0; k < 4; k++) rdp(k, (e + k) % 16);
      if (e == 3) begin wr(0, 5, 64'h1234_5678_9ABC_DEF0); iss(6); end
      cycle();
      if (e == 31) chk("ready_a_edge31", 64'(ready_a), 64'h0);
      if (e == 32) chk("ready_a_edge32", 64'(ready_a), 64'h1);
      if (e == 15) chk("ready_b_edge15", 64'(ready_b), 64'h0);
      if (e == 16) chk("ready_b_edge16", 64'(ready_b), 64'h1);
    end
    for (int r = 0; r < 32; r++) begin
      idle();
      rdp(0, r); rdp(1, (r + 16) % 32); rdp(2, r % 16); rdp(3, (r + 5) % 16);
      pre(1'b1);
      chk("cleared_a", obs_rd(0, 0) | obs_rd(0, 1), 64'h0);
      chk("cleared_b", obs_rd(1, 0) | obs_rd(1, 3), 64'h0);
      post();
    end

    // reset partway through the clear restarts the count
    idle(); set_rst(1'b1); cycle();
    for (int e = 0; e < 10; e++) begin rand_in(1'b0); cycle(); end
    idle(); set_rst(1'b1); cycle();
    for (int e = 1; e <= 32; e++) begin
      rand_in(1'b0);
      cycle();
      chk("busy_a_clear", 64'(busy_a), 64'h0);
      if (e <= 16) chk("busy_b_clear", 64'(busy_b), 64'h0);
      if (e == 31) chk("ready_a_restart31", 64'(ready_a), 64'h0);
      if (e == 32) chk("ready_a_restart32", 64'(ready_a), 64'h1);
    end

    // x5 write, x0 write dropped
    idle(); wr(0, 5, 64'hDEAD_BEEF_0123_4567); wr(1, 0, 64'hFFFF); cycle();
    idle(); rdp(0, 5); rdp(1, 0); rdp(2, 5); rdp(3, 0);
    pre(1'b1);
    chk("x5_a", obs_rd(0, 0), 64'hDEAD_BEEF_0123_4567);
    chk("x0_a", obs_rd(0, 1), 64'h0);
    chk("x5_b", obs_rd(1, 2), 64'h0123_4567);
    chk("x0_b", obs_rd(1, 3), 64'h0);
    post();

    // same-address collision: wr1 wins, in bypass and in the array
    idle(); wr(0, 7, 64'h11); wr(1, 7, 64'h22); rdp(0, 7); rdp(3, 7);
    pre(1'b1);
    chk("byp_x7_a", obs_rd(0, 0), 64'h22);
    chk("byp_x7_b", obs_rd(1, 3), 64'h22);
    post();
    idle(); rdp(0, 7);
    pre(1'b1); chk("x7_a", obs_rd(0, 0), 64'h22); post();
    idle(); wr(0, 3, 64'h33); wr(1, 4, 64'h44); cycle();
    idle(); rdp(0, 3); rdp(1, 4);
    pre(1'b1);
    chk("x3_a", obs_rd(0, 0), 64'h33);
    chk("x4_a", obs_rd(0, 1), 64'h44);
    post();

    // four ports bypassing different sources at once
    idle(); wr(0, 2, 64'hAAAA_0002); wr(1, 6, 64'hBBBB_0006);
    rdp(0, 2); rdp(1, 6); rdp(2, 3); rdp(3, 0);
    pre(1'b1);
    chk("b_p0", obs_rd(1, 0), 64'hAAAA_0002);
    chk("b_p1", obs_rd(1, 1), 64'hBBBB_0006);
    chk("b_p2", obs_rd(1, 2), 64'h33);
    chk("b_p3", obs_rd(1, 3), 64'h0);
    post();

    // scoreboard
    idle(); iss(9); cycle();
    chk("busy9_set", 64'(busy_a[9]), 64'h1);
    idle(); wr(0, 9, 64'h99); iss(9); cycle();
    chk("busy9_issue_wins", 64'(busy_a[9]), 64'h1);
    idle(); wr(1, 9, 64'h98); cycle();
    chk("busy9_clr", 64'(busy_a[9]), 64'h0);
    chk("busy9_clr_b", 64'(busy_b[9]), 64'h0);
    idle(); iss(0); cycle();
    chk("busy0_a", 64'(busy_a[0]), 64'h0);
    chk("busy0_b", 64'(busy_b[0]), 64'h0);

    // random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rand_in(1'b1);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
